// File: rtl/alu_decoder_pkg.sv
// Shared constants for the RV32I ALU decoder: ALUOp codes, ALU select codes and funct fields.
package alu_decoder_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_XOR = 3'b100;
  localparam logic [2:0] ALUC_SLT = 3'b101;
  localparam logic [2:0] ALUC_SLL = 3'b110;
  localparam logic [2:0] ALUC_SRL = 3'b111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_decoder_comb.sv
// Pure combinational ALUOp/funct decode. XOR/SLL/SRL decode only when
// ALU_DECODER_EXT_OPS_EN is defined; otherwise those funct3 values flag illegal.
module alu_decoder_comb
  import alu_decoder_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       r_type,
  output logic [2:0] alu_control,
  output logic       illegal
);

  logic f7_base;
  assign f7_base = (funct7 == F7_BASE);

  always_comb begin
    alu_control = ALUC_ADD;
    illegal     = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = ALUC_ADD;
      ALUOP_SUB: alu_control = ALUC_SUB;
      ALUOP_RSVD: illegal = 1'b1;
      default: begin
        case (funct3)
          F3_ADD: begin
            if (r_type && (funct7 == F7_ALT)) alu_control = ALUC_SUB;
            else if (r_type && !f7_base)      illegal     = 1'b1;
          end
          F3_SLT:  alu_control = ALUC_SLT;
          F3_OR:   alu_control = ALUC_OR;
          F3_AND:  alu_control = ALUC_AND;
          F3_SLTU: illegal     = 1'b1;
`ifdef ALU_DECODER_EXT_OPS_EN
          F3_XOR:  alu_control = ALUC_XOR;
          F3_SLL: begin
            alu_control = ALUC_SLL;
            illegal     = !f7_base;
          end
          F3_SR: begin
            // Shift right decodes to SRL; an arithmetic-shift funct7 is flagged illegal
            alu_control = ALUC_SRL;
            illegal     = !f7_base;
          end
`else
          default: illegal = 1'b1;
`endif
        endcase
        // R-type ops without a funct7 variant require funct7 all-zero
        if (r_type && !f7_base && (funct3 != F3_ADD) && (funct3 != F3_SLL) && (funct3 != F3_SR))
          illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_decoder.sv
// RV32I ALU decoder top: combinational select plus registered copy and sticky illegal flag.
// Optional extended ops (XOR/SLL/SRL) are enabled by defining ALU_DECODER_EXT_OPS_EN.
module alu_decoder
  import alu_decoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       illegal_clr,
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic [6:0] op,
  output logic [2:0] ALUControl,
  output logic       illegal,
  output logic [2:0] ALUControl_q,
  output logic       illegal_sticky
);

  // Only op[5] distinguishes R-type from I-type
  logic unused_op;
  assign unused_op = ^{op[6], op[4:0]};

  alu_decoder_comb u_comb (
    .alu_op      (ALUOp),
    .funct3      (funct3),
    .funct7      (funct7),
    .r_type      (op[5]),
    .alu_control (ALUControl),
    .illegal     (illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUControl_q   <= ALUC_ADD;
      illegal_sticky <= 1'b0;
    end else begin
      if (en) ALUControl_q <= ALUControl;
      // A new illegal encoding wins over a simultaneous clear
      if (illegal)          illegal_sticky <= 1'b1;
      else if (illegal_clr) illegal_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_decoder.sv
// Self-checking bench for alu_decoder: directed steps, async reset, enable hold,
// and randomized inputs against a table-driven reference model.
module tb_alu_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       illegal_clr = 1'b0;
  logic [1:0] ALUOp = 2'b00;
  logic [2:0] funct3 = 3'b000;
  logic [6:0] funct7 = 7'b0000000;
  logic [6:0] op = 7'b0000011;
  logic [2:0] ALUControl;
  logic       illegal;
  logic [2:0] ALUControl_q;
  logic       illegal_sticky;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_q;
  logic       exp_sticky;

  alu_decoder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .illegal_clr    (illegal_clr),
    .ALUOp          (ALUOp),
    .funct3         (funct3),
    .funct7         (funct7),
    .op             (op),
    .ALUControl     (ALUControl),
    .illegal        (illegal),
    .ALUControl_q   (ALUControl_q),
    .illegal_sticky (illegal_sticky)
  );

  always #5 clk = ~clk;

  // Reference: per-funct3 operation and support tables, then funct7 rules
  function automatic void model(input logic [1:0] aop, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [6:0] opc,
                                output logic [2:0] ctl, output logic ill);
    logic [2:0] op_tbl [0:7];
    logic       bad_tbl [0:7];
    logic       rt;
    logic       need_zero;
`ifdef ALU_DECODER_EXT_OPS_EN
    op_tbl  = '{3'd0, 3'd6, 3'd5, 3'd0, 3'd4, 3'd7, 3'd3, 3'd2};
    bad_tbl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    op_tbl  = '{3'd0, 3'd0, 3'd5, 3'd0, 3'd0, 3'd0, 3'd3, 3'd2};
    bad_tbl = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
    rt = opc[5];
    ctl = 3'd0;
    ill = 1'b0;
    if (aop == 2'd0) begin
      ctl = 3'd0;
    end else if (aop == 2'd1) begin
      ctl = 3'd1;
    end else if (aop == 2'd3) begin
      ill = 1'b1;
    end else begin
      ctl = op_tbl[f3];
      ill = bad_tbl[f3];
      if (f3 == 3'd0 && rt && f7 == 7'd32) begin
        ctl = 3'd1;
      end else begin
        need_zero = (f3 == 3'd1 || f3 == 3'd5) ? 1'b1 : rt;
        if (need_zero && f7 != 7'd0) ill = 1'b1;
      end
    end
  endfunction

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic apply(input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [6:0] o);
    ALUOp = a; funct3 = f3; funct7 = f7; op = o;
    #1;
  endtask

  task automatic comb_chk(input string tag, input logic [2:0] ectl, input logic eill);
    chk3({tag, ".ctl"}, ALUControl, ectl);
    chk1({tag, ".ill"}, illegal, eill);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  initial begin
    logic [2:0] mctl;
    logic       mill;

    // Reset state
    #3;
    chk3("rst_q", ALUControl_q, 3'b000);
    chk1("rst_sticky", illegal_sticky, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed combinational decode
    apply(2'b00, 3'b000, 7'b0000000, 7'b0000011); comb_chk("ld_add", 3'b000, 1'b0);
    apply(2'b01, 3'b101, 7'b1111111, 7'b1100011); comb_chk("br_sub", 3'b001, 1'b0);
    apply(2'b10, 3'b000, 7'b0000000, OP_R);       comb_chk("r_add", 3'b000, 1'b0);
    apply(2'b10, 3'b000, 7'b0100000, OP_R);       comb_chk("r_sub", 3'b001, 1'b0);
    apply(2'b10, 3'b000, 7'b0100000, OP_I);       comb_chk("i_addi", 3'b000, 1'b0);
    apply(2'b10, 3'b000, 7'b0000001, OP_R);       comb_chk("r_add_badf7", 3'b000, 1'b1);
    apply(2'b10, 3'b111, 7'b0000000, OP_R);       comb_chk("and", 3'b010, 1'b0);
    apply(2'b10, 3'b110, 7'b0000000, OP_R);       comb_chk("or", 3'b011, 1'b0);
    apply(2'b10, 3'b010, 7'b0000000, OP_R);       comb_chk("slt", 3'b101, 1'b0);
    apply(2'b10, 3'b111, 7'b0100000, OP_R);       comb_chk("and_badf7", 3'b010, 1'b1);
    apply(2'b10, 3'b110, 7'b1010101, OP_I);       comb_chk("ori_anyf7", 3'b011, 1'b0);
`ifdef ALU_DECODER_EXT_OPS_EN
    apply(2'b10, 3'b100, 7'b0000000, OP_R);       comb_chk("xor", 3'b100, 1'b0);
    apply(2'b10, 3'b001, 7'b0000000, OP_R);       comb_chk("sll", 3'b110, 1'b0);
    apply(2'b10, 3'b101, 7'b0000000, OP_R);       comb_chk("srl", 3'b111, 1'b0);
    apply(2'b10, 3'b001, 7'b0100000, OP_I);       comb_chk("slli_badf7", 3'b110, 1'b1);
    apply(2'b10, 3'b101, 7'b0100000, OP_R);       comb_chk("sra", 3'b111, 1'b1);
`else
    apply(2'b10, 3'b100, 7'b0000000, OP_R);       comb_chk("xor_off", 3'b000, 1'b1);
    apply(2'b10, 3'b001, 7'b0000000, OP_R);       comb_chk("sll_off", 3'b000, 1'b1);
    apply(2'b10, 3'b101, 7'b0000000, OP_R);       comb_chk("srl_off", 3'b000, 1'b1);
    apply(2'b10, 3'b101, 7'b0100000, OP_R);       comb_chk("sra_off", 3'b000, 1'b1);
`endif
    apply(2'b10, 3'b011, 7'b0000000, OP_R);       comb_chk("sltu", 3'b000, 1'b1);
    apply(2'b11, 3'b010, 7'b0000000, OP_R);       comb_chk("rsvd", 3'b000, 1'b1);

    // Sticky flag: set, clear blocked while illegal, clear once legal
    @(negedge clk);
    en = 1'b0; illegal_clr = 1'b0;
    apply(2'b10, 3'b011, 7'b0000000, OP_R);
    tick();
    chk1("sticky_set_sltu", illegal_sticky, 1'b1);
    @(negedge clk);
    illegal_clr = 1'b1;
    apply(2'b11, 3'b000, 7'b0000000, OP_R);
    tick();
    chk1("sticky_clr_blocked", illegal_sticky, 1'b1);
    @(negedge clk);
    apply(2'b00, 3'b000, 7'b0000000, OP_R);
    tick();
    chk1("sticky_cleared", illegal_sticky, 1'b0);
    @(negedge clk);
    illegal_clr = 1'b0;
    apply(2'b10, 3'b101, 7'b0100000, OP_R);
    tick();
    chk1("sticky_set_sra", illegal_sticky, 1'b1);

    // Capture, enable hold, then asynchronous reset mid-cycle
    @(negedge clk);
    en = 1'b1;
    apply(2'b01, 3'b000, 7'b0000000, OP_R);
    tick();
    chk3("q_capture_sub", ALUControl_q, 3'b001);
    @(negedge clk);
    en = 1'b0;
    apply(2'b10, 3'b111, 7'b0000000, OP_R);
    tick();
    chk3("q_hold_en0", ALUControl_q, 3'b001);
    @(negedge clk);
    apply(2'b10, 3'b010, 7'b0000000, OP_R);
    tick();
    chk3("q_hold_en0_b", ALUControl_q, 3'b001);
    chk1("sticky_before_rst", illegal_sticky, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk3("async_rst_q", ALUControl_q, 3'b000);
    chk1("async_rst_sticky", illegal_sticky, 1'b0);
    comb_chk("comb_in_rst", 3'b101, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    comb_chk("comb_after_rst", 3'b101, 1'b0);

    // Randomized sweep with registered-output tracking
    exp_q = 3'b000;
    exp_sticky = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      en = 1'($urandom_range(0, 1));
      illegal_clr = 1'($urandom_range(0, 1));
      apply(2'($urandom), 3'($urandom), ($urandom_range(0, 3) == 0) ? 7'($urandom) :
            (($urandom_range(0, 1) == 0) ? 7'b0000000 : 7'b0100000), 7'($urandom));
      model(ALUOp, funct3, funct7, op, mctl, mill);
      comb_chk("rand_comb", mctl, mill);
      if (en) exp_q = mctl;
      if (mill) exp_sticky = 1'b1;
      else if (illegal_clr) exp_sticky = 1'b0;
      tick();
      chk3("rand_q", ALUControl_q, exp_q);
      chk1("rand_sticky", illegal_sticky, exp_sticky);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
